// File: rtl/disp_pkg.sv
// Shared types and constants for the two-digit seven-segment scan scheduler.
package disp_pkg;

  // Scan order: BLANK_L -> SHOW_L -> BLANK_R -> SHOW_R -> BLANK_L
  typedef enum logic [1:0] {
    BLANK_L = 2'd0,
    SHOW_L  = 2'd1,
    BLANK_R = 2'd2,
    SHOW_R  = 2'd3
  } scan_state_t;

  // Active-low segments: all ones turns every segment off
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-high digit enables; 2'b11 is never produced
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_NONE  = 2'b00;

  // Successor of a scan state in the fixed rotation
  function automatic scan_state_t next_scan_state(input scan_state_t s);
    scan_state_t n;
    n = BLANK_L;
    case (s)
      BLANK_L: n = SHOW_L;
      SHOW_L:  n = BLANK_R;
      BLANK_R: n = SHOW_R;
      SHOW_R:  n = BLANK_L;
      default: n = BLANK_L;
    endcase
    return n;
  endfunction

  // True for the two states that drive a digit
  function automatic logic is_show(input scan_state_t s);
    return (s == SHOW_L) || (s == SHOW_R);
  endfunction

endpackage

// File: rtl/display_mux_scheduler_hex_to_seg.sv
// Combinational hex digit to active-low seven-segment pattern (a..g on bits 6..0).
module hex_to_seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Lookup of the 16 hex glyphs; lower-case b and d keep them distinct from 8 and 0
  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0001100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/display_mux_scheduler.sv
// Two-digit seven-segment scan scheduler: left/right alternation with blanking
// dead time, 16-level PWM brightness and frame-synchronous double-buffered updates.
module display_mux_scheduler
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 32768,
  parameter int BLANK_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [3:0] left_in,
  input  logic [3:0] right_in,
  input  logic [3:0] bright,
  output logic [6:0] seg,
  output logic [1:0] select,
  output logic       frame_done
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [3:0]       pwm_q, pwm_d;
  logic [3:0]       left_act_q, left_act_d, right_act_q, right_act_d;
  logic [3:0]       left_shd_q, left_shd_d, right_shd_q, right_shd_d;
  logic             shd_full_q, shd_full_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       select_q, select_d;
  logic             frame_done_q, frame_done_d;

  logic             phase_last;
  logic             frame_boundary;
  logic [3:0]       digit_mux;
  logic [6:0]       seg_dec;

  // Only SHOW states light a digit, so the mux picks by the upcoming state.
  // Active registers never change on an edge that enters a SHOW state.
  assign digit_mux = (state_d == SHOW_L) ? left_act_q : right_act_q;

  hex_to_seg u_hex_to_seg (
    .hex_i (digit_mux),
    .seg_o (seg_dec)
  );

  assign upd_ready  = ~shd_full_q;
  assign seg        = seg_q;
  assign select     = select_q;
  assign frame_done = frame_done_q;

  // Scan sequencing, PWM counter and shadow/active update handshake
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    pwm_d          = pwm_q;
    left_act_d     = left_act_q;
    right_act_d    = right_act_q;
    left_shd_d     = left_shd_q;
    right_shd_d    = right_shd_q;
    shd_full_d     = shd_full_q;
    phase_last     = is_show(state_q) ? (phase_q == DIGIT_LAST) : (phase_q == BLANK_LAST);
    frame_boundary = enable && (state_q == SHOW_R) && phase_last;

    if (!enable) begin
      state_d = BLANK_L;
      phase_d = '0;
      pwm_d   = 4'd0;
    end else begin
      if (phase_last) begin
        state_d = next_scan_state(state_q);
        phase_d = '0;
      end else begin
        phase_d = phase_q + CNT_W'(1);
      end
      if (is_show(state_d) && (state_d != state_q)) begin
        pwm_d = 4'd0;
      end else if (is_show(state_q)) begin
        pwm_d = pwm_q + 4'd1;
      end
    end

    frame_done_d = frame_boundary;

    // Accept and promote are exclusive: accept needs an empty shadow, promote a full one
    if (upd_valid && !shd_full_q) begin
      left_shd_d  = left_in;
      right_shd_d = right_in;
      shd_full_d  = 1'b1;
    end
    if (shd_full_q && (frame_boundary || !enable)) begin
      left_act_d  = left_shd_q;
      right_act_d = right_shd_q;
      shd_full_d  = 1'b0;
    end
  end

  // Output decode for the post-edge state, gated by the PWM compare
  always_comb begin
    select_d = SEL_NONE;
    seg_d    = SEG_BLANK;
    if (state_d == SHOW_L) begin
      select_d = SEL_LEFT;
      seg_d    = (pwm_d <= bright) ? seg_dec : SEG_BLANK;
    end else if (state_d == SHOW_R) begin
      select_d = SEL_RIGHT;
      seg_d    = (pwm_d <= bright) ? seg_dec : SEG_BLANK;
    end
  end

  // State, buffers and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BLANK_L;
      phase_q      <= '0;
      pwm_q        <= 4'd0;
      left_act_q   <= 4'd0;
      right_act_q  <= 4'd0;
      left_shd_q   <= 4'd0;
      right_shd_q  <= 4'd0;
      shd_full_q   <= 1'b0;
      seg_q        <= SEG_BLANK;
      select_q     <= SEL_NONE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pwm_q        <= pwm_d;
      left_act_q   <= left_act_d;
      right_act_q  <= right_act_d;
      left_shd_q   <= left_shd_d;
      right_shd_q  <= right_shd_d;
      shd_full_q   <= shd_full_d;
      seg_q        <= seg_d;
      select_q     <= select_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_display_mux_scheduler.sv
// Scoreboard bench: the driver queues cycle-tagged expected outputs, a negedge
// monitor pops and compares them; a random phase checks select never overlaps.
module tb_display_mux_scheduler;

  logic       clk;
  logic       reset, enable, enable_b, upd_valid;
  logic [3:0] left_in, right_in, bright;
  logic       upd_ready, upd_ready_b, frame_done, frame_done_b;
  logic [6:0] seg, seg_b;
  logic [1:0] select, select_b;

  display_mux_scheduler #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .left_in(left_in), .right_in(right_in),
    .bright(bright), .seg(seg), .select(select), .frame_done(frame_done)
  );

  display_mux_scheduler #(.DIGIT_CYCLES(32), .BLANK_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .upd_valid(upd_valid),
    .upd_ready(upd_ready_b), .left_in(left_in), .right_in(right_in),
    .bright(bright), .seg(seg_b), .select(select_b), .frame_done(frame_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         which;
    logic [1:0] sel;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   trans = 0;
  int   zeros = 0;
  logic [1:0] last_nz = 2'b00;
  bit   rand_on = 0;
  bit   rand_prev = 0;
  exp_t em;
  logic [1:0] a_sel;
  logic [6:0] a_seg;
  logic a_fd, a_rdy;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expectation due this cycle and compare; overlap checks in random phase
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      em = q.pop_front();
      checks++;
      if (em.which) begin
        a_sel = select_b; a_seg = seg_b; a_fd = frame_done_b; a_rdy = upd_ready_b;
      end else begin
        a_sel = select; a_seg = seg; a_fd = frame_done; a_rdy = upd_ready;
      end
      if (em.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", em.nm, em.cyc, cyc);
      end else if (a_sel !== em.sel || a_seg !== em.seg || a_fd !== em.fd || a_rdy !== em.rdy) begin
        errors++;
        $display("FAIL %s cyc=%0d: got sel=%b seg=%b fd=%b rdy=%b, expected sel=%b seg=%b fd=%b rdy=%b",
                 em.nm, cyc, a_sel, a_seg, a_fd, a_rdy, em.sel, em.seg, em.fd, em.rdy);
      end else begin
        $display("ok   %s cyc=%0d sel=%b seg=%b fd=%b rdy=%b", em.nm, cyc, a_sel, a_seg, a_fd, a_rdy);
      end
    end
    if (rand_on) begin
      checks++;
      if (select === 2'b11) begin
        errors++;
        $display("FAIL sel_11 cyc=%0d: got select=%b, required not 11", cyc, select);
      end
      if (select != 2'b00) begin
        if (last_nz != 2'b00 && select != last_nz) begin
          trans++;
          checks++;
          if (zeros < 2) begin
            errors++;
            $display("FAIL dead_time cyc=%0d: got %0d blank cycles between %b and %b, required >= 2",
                     cyc, zeros, last_nz, select);
          end
        end
        last_nz = select;
        zeros = 0;
      end else begin
        zeros++;
      end
    end else begin
      if (rand_prev) begin
        checks++;
        if (trans < 1900) begin
          errors++;
          $display("FAIL digit_transitions: got %0d, required >= 1900", trans);
        end else begin
          $display("ok   digit_transitions=%0d", trans);
        end
      end
      last_nz = 2'b00;
      zeros = 0;
    end
    rand_prev = rand_on;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit which, input logic [1:0] s, input logic [6:0] g,
                      input logic f, input logic r, input string nm);
    exp_t e;
    e.cyc = cyc; e.which = which; e.sel = s; e.seg = g; e.fd = f; e.rdy = r; e.nm = nm;
    q.push_back(e);
  endtask

  // Hand timeline of a 20-cycle frame (2 blank, 8 left, 2 blank, 8 right), bright=15
  task automatic push_std(input int k, input logic [6:0] lp, input logic [6:0] rp,
                          input bit fd0, input logic rdy, input string nm);
    int p;
    p = k % 20;
    if (p < 2 || (p >= 10 && p < 12)) push(1'b0, 2'b00, 7'h7F, fd0 && (p == 0), rdy, nm);
    else if (p < 10) push(1'b0, 2'b10, lp, 1'b0, rdy, nm);
    else push(1'b0, 2'b01, rp, 1'b0, rdy, nm);
  endtask

  initial begin
    logic [6:0] lp, rp;
    logic       rdy;
    reset = 1'b1; enable = 1'b0; enable_b = 1'b0; upd_valid = 1'b0;
    left_in = 4'h0; right_in = 4'h0; bright = 4'hF;
    tick(); tick(); tick();
    push(1'b0, 2'b00, 7'h7F, 1'b0, 1'b1, "reset_state");
    push(1'b1, 2'b00, 7'h7F, 1'b0, 1'b1, "reset_state_b");
    tick();

    // Basic scan, update at frame boundary, busy ignore, simultaneous accept, enable drop
    reset = 1'b0; enable = 1'b1;
    for (int k = 0; k < 96; k++) begin
      upd_valid = 1'b0;
      if (k == 25) begin upd_valid = 1'b1; left_in = 4'hA; right_in = 4'h3; end
      if (k == 30) begin upd_valid = 1'b1; left_in = 4'h7; right_in = 4'h7; end
      if (k == 59) begin upd_valid = 1'b1; left_in = 4'h5; right_in = 4'h9; end
      if (k < 40)      begin lp = 7'h01; rp = 7'h01; end
      else if (k < 80) begin lp = 7'h08; rp = 7'h06; end
      else             begin lp = 7'h24; rp = 7'h0C; end
      rdy = (k <= 25) || (k >= 40 && k <= 59) || (k >= 80);
      push_std(k, lp, rp, k >= 20, rdy, "scan_update");
      if (k == 95) enable = 1'b0;
      tick();
    end

    // Disabled: blank, no frame pulse, update copied to active straight away
    for (int j = 0; j < 8; j++) begin
      upd_valid = 1'b0;
      if (j == 1) begin upd_valid = 1'b1; left_in = 4'h1; right_in = 4'h2; end
      push(1'b0, 2'b00, 7'h7F, 1'b0, (j != 2), "disabled");
      tick();
    end

    // Restart from BLANK_L cycle 0 showing 1/2, then reset with a pending shadow
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      upd_valid = 1'b0;
      if (k == 3) begin upd_valid = 1'b1; left_in = 4'h8; right_in = 4'h8; end
      push_std(k, 7'h4F, 7'h12, 1'b0, (k <= 3), "restart");
      if (k == 5) reset = 1'b1;
      tick();
    end
    upd_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      push(1'b0, 2'b00, 7'h7F, 1'b0, 1'b1, "reset_mid");
      if (r == 1) reset = 1'b0;
      tick();
    end
    for (int k = 1; k <= 40; k++) begin
      push_std(k, 7'h01, 7'h01, k >= 20, 1'b1, "after_reset");
      tick();
    end

    // Brightness on the 32-cycle instance: 8 left, 1 right, bright=3
    upd_valid = 1'b1; left_in = 4'h8; right_in = 4'h1; bright = 4'd3;
    tick();
    upd_valid = 1'b0;
    tick(); tick();
    enable_b = 1'b1;
    for (int k = 0; k <= 68; k++) begin
      if (k >= 2 && k < 34)
        push(1'b1, 2'b10, (((k - 2) % 16) <= 3) ? 7'h00 : 7'h7F, 1'b0, 1'b1, "bright_left");
      else if (k >= 36 && k < 68)
        push(1'b1, 2'b01, (((k - 36) % 16) <= 3) ? 7'h4F : 7'h7F, 1'b0, 1'b1, "bright_right");
      else
        push(1'b1, 2'b00, 7'h7F, (k == 68), 1'b1, "bright_blank");
      tick();
    end
    enable_b = 1'b0;

    // Random updates and brightness over 1000 frames; monitor checks select overlap
    rand_on = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      bright    = 4'($urandom_range(0, 15));
      upd_valid = ($urandom_range(0, 3) == 0);
      left_in   = 4'($urandom_range(0, 15));
      right_in  = 4'($urandom_range(0, 15));
      tick();
    end
    rand_on = 1'b0;
    upd_valid = 1'b0;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
